// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the 32x32 regfile write port, with read-after-write hit lookup.
// Define WB_BYPASS_EN to also forward the youngest pending data for each lookup address.
module regfile_wb_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [ADDR_W-1:0]        InAddr,
    input  logic [DATA_W-1:0]        InData,
    input  logic                     DrainEn,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        WriteRegister,
    output logic [DATA_W-1:0]        WriteData,
    input  logic [ADDR_W-1:0]        ReadRegister1,
    input  logic [ADDR_W-1:0]        ReadRegister2,
    output logic                     Hit1,
    output logic                     Hit2,
    output logic [DATA_W-1:0]        BypassData1,
    output logic [DATA_W-1:0]        BypassData2,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty,
    output logic                     Full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic accept_c, push_c, pop_c;
    logic [PTR_W-1:0] idx;

    assign Empty    = (count_q == '0);
    assign Full     = (count_q == CNT_W'(DEPTH));
    assign Count    = count_q;
    assign InReady  = !Full;
    assign accept_c = InValid && InReady;
    // Writes to r0 complete the handshake but are dropped: r0 is hardwired zero.
    assign push_c   = accept_c && (InAddr != '0);
    assign RegWrite = DrainEn && !Empty;
    assign pop_c    = RegWrite;

    assign WriteRegister = Empty ? '0 : addr_q[head_q];
    assign WriteData     = Empty ? '0 : data_q[head_q];

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_c)  head_d = head_q + PTR_W'(1);
        if (push_c) tail_d = tail_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (pop_c) valid_q[head_q] <= 1'b0;
            if (push_c) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= InAddr;
                data_q[tail_q]  <= InData;
            end
        end
    end

    logic [DATA_W-1:0] byp1_c, byp2_c;

    // Walk oldest to youngest so the last match is the youngest pending write.
    always_comb begin
        Hit1   = 1'b0;
        Hit2   = 1'b0;
        byp1_c = '0;
        byp2_c = '0;
        idx    = head_q;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head_q + PTR_W'(k);
            if (valid_q[idx] && (ReadRegister1 != '0) && (addr_q[idx] == ReadRegister1)) begin
                Hit1 = 1'b1;
`ifdef WB_BYPASS_EN
                byp1_c = data_q[idx];
`endif
            end
            if (valid_q[idx] && (ReadRegister2 != '0) && (addr_q[idx] == ReadRegister2)) begin
                Hit2 = 1'b1;
`ifdef WB_BYPASS_EN
                byp2_c = data_q[idx];
`endif
            end
        end
    end

    assign BypassData1 = byp1_c;
    assign BypassData2 = byp2_c;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed vector bench for regfile_wb_queue; expectations follow WB_BYPASS_EN if defined.
module tb_regfile_wb_queue;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk, Rst_n;
    logic        InValid, InReady, DrainEn;
    logic [4:0]  InAddr, WriteRegister, ReadRegister1, ReadRegister2;
    logic [31:0] InData, WriteData, BypassData1, BypassData2;
    logic        RegWrite, Hit1, Hit2, Empty, Full;
    logic [2:0]  Count;

    int total = 0;
    int bad   = 0;

    regfile_wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .InValid(InValid), .InReady(InReady), .InAddr(InAddr), .InData(InData),
        .DrainEn(DrainEn), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .Hit1(Hit1), .Hit2(Hit2), .BypassData1(BypassData1), .BypassData2(BypassData2),
        .Count(Count), .Empty(Empty), .Full(Full)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        dr;
        logic [4:0]  r1, r2;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        rdy, h1, h2;
        logic [31:0] b1, b2;
        logic [2:0]  cnt;
    } vec_t;

    localparam int NV = 21;
    vec_t tv [NV];

    function automatic vec_t mk(int v, int a, logic [31:0] d, int dr, int r1, int r2,
                                int rw, int wr, logic [31:0] wd, int rdy, int h1, int h2,
                                logic [31:0] b1, logic [31:0] b2, int cnt);
        vec_t t;
        t.v = 1'(v);   t.a = 5'(a);   t.d = d;   t.dr = 1'(dr);
        t.r1 = 5'(r1); t.r2 = 5'(r2); t.rw = 1'(rw); t.wr = 5'(wr); t.wd = wd;
        t.rdy = 1'(rdy); t.h1 = 1'(h1); t.h2 = 1'(h2);
        t.b1 = b1; t.b2 = b2; t.cnt = 3'(cnt);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic dr, input logic [4:0] r1, input logic [4:0] r2);
        InValid = v; InAddr = a; InData = d; DrainEn = dr;
        ReadRegister1 = r1; ReadRegister2 = r2;
    endtask

    initial begin
        //          v  a   d             dr r1 r2  rw wr wd            rdy h1 h2 b1            b2            cnt
        tv[0]  = mk(1, 5,  32'hDEADBEEF, 1, 5, 0,  0, 0, 32'h0,        1,  0, 0, 32'h0,        32'h0,        0);
        tv[1]  = mk(0, 0,  32'h0,        1, 5, 5,  1, 5, 32'hDEADBEEF, 1,  1, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1);
        tv[2]  = mk(1, 0,  32'h12345678, 1, 0, 5,  0, 0, 32'h0,        1,  0, 0, 32'h0,        32'h0,        0);
        tv[3]  = mk(0, 0,  32'h0,        1, 0, 0,  0, 0, 32'h0,        1,  0, 0, 32'h0,        32'h0,        0);
        tv[4]  = mk(1, 1,  32'h101,      0, 1, 0,  0, 0, 32'h0,        1,  0, 0, 32'h0,        32'h0,        0);
        tv[5]  = mk(1, 2,  32'h102,      0, 1, 2,  0, 1, 32'h101,      1,  1, 0, 32'h101,      32'h0,        1);
        tv[6]  = mk(1, 3,  32'h103,      0, 2, 3,  0, 1, 32'h101,      1,  1, 0, 32'h102,      32'h0,        2);
        tv[7]  = mk(1, 4,  32'h104,      0, 3, 4,  0, 1, 32'h101,      1,  1, 0, 32'h103,      32'h0,        3);
        tv[8]  = mk(1, 9,  32'h109,      0, 4, 9,  0, 1, 32'h101,      0,  1, 0, 32'h104,      32'h0,        4);
        tv[9]  = mk(0, 0,  32'h0,        1, 1, 0,  1, 1, 32'h101,      0,  1, 0, 32'h101,      32'h0,        4);
        tv[10] = mk(0, 0,  32'h0,        1, 9, 4,  1, 2, 32'h102,      1,  0, 1, 32'h0,        32'h104,      3);
        tv[11] = mk(0, 0,  32'h0,        1, 3, 1,  1, 3, 32'h103,      1,  1, 0, 32'h103,      32'h0,        2);
        tv[12] = mk(0, 0,  32'h0,        1, 4, 4,  1, 4, 32'h104,      1,  1, 1, 32'h104,      32'h104,      1);
        tv[13] = mk(1, 7,  32'h11,       0, 7, 0,  0, 0, 32'h0,        1,  0, 0, 32'h0,        32'h0,        0);
        tv[14] = mk(1, 7,  32'h22,       0, 7, 0,  0, 7, 32'h11,       1,  1, 0, 32'h11,       32'h0,        1);
        tv[15] = mk(0, 0,  32'h0,        0, 7, 0,  0, 7, 32'h11,       1,  1, 0, 32'h22,       32'h0,        2);
        tv[16] = mk(1, 8,  32'h33,       0, 8, 7,  0, 7, 32'h11,       1,  0, 1, 32'h0,        32'h22,       2);
        tv[17] = mk(1, 10, 32'h44,       0, 8, 10, 0, 7, 32'h11,       1,  1, 0, 32'h33,       32'h0,        3);
        tv[18] = mk(1, 12, 32'h55,       1, 10, 7, 1, 7, 32'h11,       0,  1, 1, 32'h44,       32'h22,       4);
        tv[19] = mk(1, 12, 32'h55,       1, 7, 12, 1, 7, 32'h22,       1,  1, 0, 32'h22,       32'h0,        3);
        tv[20] = mk(0, 0,  32'h0,        0, 12, 7, 0, 8, 32'h33,       1,  1, 0, 32'h55,       32'h0,        3);

        Rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        repeat (2) @(negedge Clk);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_inready",  32'(InReady),  32'd1);
        chk("rst_empty",    32'(Empty),    32'd1);
        chk("rst_full",     32'(Full),     32'd0);
        chk("rst_count",    32'(Count),    32'd0);
        chk("rst_hits",     32'({Hit1, Hit2}), 32'd0);
        chk("rst_byp",      BypassData1 | BypassData2, 32'd0);
        Rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge Clk);
            drive(tv[i].v, tv[i].a, tv[i].d, tv[i].dr, tv[i].r1, tv[i].r2);
            #1;
            chk($sformatf("v%0d_regwrite", i), 32'(RegWrite),      32'(tv[i].rw));
            chk($sformatf("v%0d_wreg", i),     32'(WriteRegister), 32'(tv[i].wr));
            chk($sformatf("v%0d_wdata", i),    WriteData,          tv[i].wd);
            chk($sformatf("v%0d_inready", i),  32'(InReady),       32'(tv[i].rdy));
            chk($sformatf("v%0d_hit1", i),     32'(Hit1),          32'(tv[i].h1));
            chk($sformatf("v%0d_hit2", i),     32'(Hit2),          32'(tv[i].h2));
            chk($sformatf("v%0d_byp1", i),     BypassData1,        BYP ? tv[i].b1 : 32'h0);
            chk($sformatf("v%0d_byp2", i),     BypassData2,        BYP ? tv[i].b2 : 32'h0);
            chk($sformatf("v%0d_count", i),    32'(Count),         32'(tv[i].cnt));
            chk($sformatf("v%0d_empty", i),    32'(Empty),         32'(tv[i].cnt == 3'd0));
            chk($sformatf("v%0d_full", i),     32'(Full),          32'(tv[i].cnt == 3'd4));
        end

        // Three entries pending (8, 10, 12); assert reset asynchronously mid-cycle.
        @(negedge Clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd12);
        #1;
        chk("pre_rst_count", 32'(Count), 32'd3);
        chk("pre_rst_hit1",  32'(Hit1),  32'd1);
        #1 Rst_n = 1'b0;
        #1;
        chk("async_regwrite", 32'(RegWrite), 32'd0);
        chk("async_empty",    32'(Empty),    32'd1);
        chk("async_hit1",     32'(Hit1),     32'd0);
        chk("async_hit2",     32'(Hit2),     32'd0);
        chk("async_wreg",     32'(WriteRegister), 32'd0);
        chk("async_byp1",     BypassData1,   32'h0);
        @(negedge Clk);
        chk("inrst_regwrite", 32'(RegWrite), 32'd0);
        chk("inrst_inready",  32'(InReady),  32'd1);
        Rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            #1;
            chk($sformatf("post_rst%0d_regwrite", c), 32'(RegWrite), 32'd0);
            chk($sformatf("post_rst%0d_count", c),    32'(Count),    32'd0);
            chk($sformatf("post_rst%0d_hit", c),      32'({Hit1, Hit2}), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side initiator for the 32x32 MIPS register file. It buffers write-back requests in a small FIFO and drains them onto the regfile write port (RegWrite/WriteRegister/WriteData), at most one per cycle.
- It also reports read-after-write hazards against the regfile read addresses and, optionally, forwards the youngest pending data.
- It sits between the execute/memory write-back stage and the regfile.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, >=2)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- InValid  in  1  write-back request valid
- InReady  out  1  queue can accept a request
- InAddr  in  ADDR_W  destination register of the request
- InData  in  DATA_W  data of the request
- DrainEn  in  1  permission to use the regfile write port this cycle
- RegWrite  out  1  regfile write enable
- WriteRegister  out  ADDR_W  regfile write address
- WriteData  out  DATA_W  regfile write data
- ReadRegister1  in  ADDR_W  lookup address, port 1
- ReadRegister2  in  ADDR_W  lookup address, port 2
- Hit1  out  1  pending write to ReadRegister1 exists
- Hit2  out  1  pending write to ReadRegister2 exists
- BypassData1  out  DATA_W  youngest pending data for ReadRegister1
- BypassData2  out  DATA_W  youngest pending data for ReadRegister2
- Count  out  $clog2(DEPTH)+1  occupied entries
- Empty  out  1  Count==0
- Full  out  1  Count==DEPTH

Behaviour:
- Reset (async assert, sync release): head, tail and Count are 0; all entry valid bits clear.
  - Outputs during/after reset: RegWrite=0, InReady=1, Empty=1, Full=0, Hit1=Hit2=0, BypassData1/2=0.
  - Reset mid-operation discards all pending entries; no regfile write occurs during reset.
- InReady = !Full (combinational). Accept = InValid & InReady.
- Accept with InAddr==0: request is consumed (handshake completes) but not enqueued, because reg 0 is hardwired zero.
- Accept with InAddr!=0: entry written at tail, tail wraps modulo DEPTH.
- Entries are FIFO ordered. Duplicate addresses are allowed and are not merged.
- Write port (combinational from head):
  - RegWrite = DrainEn & !Empty
  - WriteRegister = head addr; WriteData = head data
  - When Empty, WriteRegister=0 and WriteData=0.
- Pop on the rising edge when RegWrite=1; head wraps modulo DEPTH. The regfile commits on that same edge.
- Latency: a request accepted at edge N into an empty queue drives RegWrite in cycle N..N+1 and is written at edge N+1 if DrainEn=1. DrainEn=0 holds the head indefinitely.
- Simultaneous push and pop:
  - When not full, Count is unchanged and both occur.
  - When full, InReady=0, so no push even if a pop occurs this cycle; there is no pass-through.
- Hit lookup (combinational, over valid entries only):
  - Hitk = (ReadRegisterk!=0) & any valid entry addr==ReadRegisterk.
  - The head entry being written this cycle still counts as a hit.
  - The incoming InAddr/InData of the current cycle is not visible to the lookup.
- Youngest match = the matching entry closest to tail (latest enqueued).
- Count, Empty and Full reflect registered state only.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: BypassDatak = data of the youngest valid entry matching ReadRegisterk when Hitk=1, else 0.
- Not defined: BypassData1/2 are tied to 0 and no priority-select logic is built. Hit1/Hit2 are unchanged, so the consumer must stall on a hit. Port list is identical in both builds.

Test Plan:
- Reset, then push (addr 5, 0xDEADBEEF) with DrainEn=1 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; after that edge Empty=1, Count=0.
- Push addr 0 data 0x12345678 -> InReady=1, Count stays 0, RegWrite never asserts.
- DrainEn=0, push 4 entries (addrs 1,2,3,4) -> Full=1, InReady=0; a 5th InValid is not accepted. DrainEn=1 -> writes occur in order 1,2,3,4 on four consecutive edges.
- DrainEn=0, push (7, 0x11) then (7, 0x22), ReadRegister1=7, ReadRegister2=0 -> Hit1=1, Hit2=0. With WB_BYPASS_EN, BypassData1=0x22; without it, BypassData1=0.
- Full queue with DrainEn=1 and InValid=1 in the same cycle -> one pop, no push, Count=3. Next cycle the push is accepted and Count stays 3.
- Assert Rst_n=0 asynchronously mid-cycle with 3 entries pending -> RegWrite=0, Empty=1 and Hit1=0 immediately. After release, no stale writes occur.
